// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button synchroniser, debouncer and short/long press classifier
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16,
    parameter int CNT_W           = 8
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_b,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_long;
    state_t           r_state;

    logic w_differs;
    logic w_commit;
    logic w_rise;
    logic w_fall;

    assign w_differs = (r_s2 != r_level);
    assign w_commit  = w_differs && (r_db_cnt == DB_LAST);
    assign w_rise    = w_commit && r_s2;
    assign w_fall    = w_commit && !r_s2;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_state    <= IDLE;
        end else begin
            r_s1      <= in_b;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;

            // Any cycle agreeing with the committed level restarts the count.
            if (!w_differs) begin
                r_db_cnt <= '0;
            end else if (w_commit) begin
                r_db_cnt <= '0;
                r_level  <= r_s2;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state    <= PRESSED;
                        r_press    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                PRESSED: begin
                    // Release takes priority over reaching the long threshold.
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                        r_short   <= 1'b1;
                    end else if (r_hold_cnt == LONG_LAST) begin
                        r_state <= LONG;
                        r_long  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_short   = r_short;
    assign o_long    = r_long;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

    logic in_clk;
    logic in_rst;
    logic in_b;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_short;
    logic o_long;

    int n_vec;
    int n_err;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16),
        .CNT_W          (8)
    ) dut (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_b     (in_b),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_short  (o_short),
        .o_long   (o_long)
    );

    initial in_clk = 1'b0;
    always #10 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge in_clk);
        in_b   = 1'b0;
        in_rst = 1'b1;
        repeat (2) @(negedge in_clk);
        in_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        in_rst = 1'b1;
        in_b   = 1'b0;
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        outs = {o_level, o_press, o_release, o_short, o_long};
        n_vec++;
        if (outs !== 5'b0) begin
            n_err++;
            $display("FAIL reset_idle: outputs=%b required=%b", outs, 5'b0);
        end
        in_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge in_clk);
            outs = {o_level, o_press, o_release, o_short, o_long};
            n_vec++;
            if (outs !== 5'b0) begin
                n_err++;
                $display("FAIL reset_held_b1 cyc%0d: outputs=%b required=%b", k, outs, 5'b0);
            end
        end
        in_b = 1'b0;
        repeat (3) @(negedge in_clk);
        in_rst = 1'b0;
    endtask

    task automatic test_clean_press();
        apply_reset();
        in_b = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge in_clk);
            n_vec++;
            if (o_level !== (k >= 5)) begin
                n_err++;
                $display("FAIL clean_level E%0d: got=%b required=%b", k, o_level, (k >= 5));
            end
            n_vec++;
            if (o_press !== (k == 5)) begin
                n_err++;
                $display("FAIL clean_press E%0d: got=%b required=%b", k, o_press, (k == 5));
            end
        end
    endtask

    task automatic test_bounce();
        logic bpat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int n_press = 0;
        int press_k = -1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_b = bpat[i];
            @(negedge in_clk);
            if (o_press) n_press++;
        end
        in_b = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge in_clk);
            if (o_press) begin
                n_press++;
                press_k = k;
            end
        end
        n_vec++;
        if (n_press !== 1) begin
            n_err++;
            $display("FAIL bounce_press_count: got=%0d required=1", n_press);
        end
        n_vec++;
        if (press_k !== 5) begin
            n_err++;
            $display("FAIL bounce_press_edge: got=%0d required=5", press_k);
        end
    endtask

    task automatic wait_press(input string name);
        bit found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge in_clk);
            if (o_press) begin
                found = 1;
                break;
            end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL %s_press_timeout: got=no press required=press within 20 cycles", name);
        end
    endtask

    task automatic check_release(input string name, input int hold, input int exp_short);
        int rel_k = -1;
        int n_rel = 0;
        int n_short = 0;
        int n_long = 0;
        repeat (hold) @(negedge in_clk);
        in_b = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge in_clk);
            if (o_release) begin
                n_rel++;
                rel_k = k;
            end
            if (o_short) begin
                n_short++;
                if (!o_release) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL %s_short_alone: got short without release required=with release", name);
                end
            end
            if (o_long) n_long++;
        end
        n_vec++;
        if (n_rel !== 1 || rel_k !== 5) begin
            n_err++;
            $display("FAIL %s_release: got count=%0d edge=%0d required count=1 edge=5", name, n_rel, rel_k);
        end
        n_vec++;
        if (n_short !== exp_short) begin
            n_err++;
            $display("FAIL %s_short: got=%0d required=%0d", name, n_short, exp_short);
        end
        n_vec++;
        if (n_long !== 0) begin
            n_err++;
            $display("FAIL %s_no_long: got=%0d required=0", name, n_long);
        end
        n_vec++;
        if (o_level !== 1'b0) begin
            n_err++;
            $display("FAIL %s_level_after: got=%b required=0", name, o_level);
        end
    endtask

    task automatic test_short_press();
        apply_reset();
        in_b = 1'b1;
        wait_press("short");
        check_release("short", 8, 1);
    endtask

    task automatic test_release_wins();
        apply_reset();
        in_b = 1'b1;
        wait_press("relwin");
        check_release("relwin", 10, 1);
    endtask

    task automatic test_long_press();
        int n_long = 0;
        int long_k = -1;
        apply_reset();
        in_b = 1'b1;
        wait_press("long");
        for (int k = 1; k <= 30; k++) begin
            @(negedge in_clk);
            if (o_long) begin
                n_long++;
                long_k = k;
            end
        end
        n_vec++;
        if (n_long !== 1 || long_k !== 16) begin
            n_err++;
            $display("FAIL long_pulse: got count=%0d edge=%0d required count=1 edge=16", n_long, long_k);
        end
        n_vec++;
        if (o_level !== 1'b1) begin
            n_err++;
            $display("FAIL long_level_held: got=%b required=1", o_level);
        end
        check_release("long", 0, 0);
    endtask

    task automatic test_reset_mid_press();
        logic [4:0] outs;
        int n_press = 0;
        int press_k = -1;
        apply_reset();
        in_b = 1'b1;
        wait_press("midrst");
        repeat (3) @(negedge in_clk);
        in_rst = 1'b1;
        @(negedge in_clk);
        outs = {o_level, o_press, o_release, o_short, o_long};
        n_vec++;
        if (outs !== 5'b0) begin
            n_err++;
            $display("FAIL midrst_outputs: outputs=%b required=%b", outs, 5'b0);
        end
        in_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge in_clk);
            if (o_press) begin
                n_press++;
                press_k = k;
            end
        end
        n_vec++;
        if (n_press !== 1 || press_k !== 5) begin
            n_err++;
            $display("FAIL midrst_repress: got count=%0d edge=%0d required count=1 edge=5", n_press, press_k);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        in_rst = 1'b1;
        in_b   = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_long_press();
        test_release_wins();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
